// File: rtl/ord_responder.sv
// ord_responder: responder side of the ORD fetch/return handshake.
// Fetches (start2/ack2) are served from a free-running LFSR byte stream and
// returns (start3/ack3) are checked against a LIFO history of served bytes,
// so returns are expected in reverse order of service.
// Build option ORD_RESP_CHECK_EN: when defined, the history RAM is built and
// returned bytes are compared (err[0] live); when undefined, only occupancy
// is tracked, R is ignored and err[0] stays 0. Handshake timing is identical.

module ord_responder #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 16,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(8'h01),
    parameter int               ACK_DELAY = 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         start2,
    output logic                         ack2,
    output logic [WIDTH-1:0]             B,
    input  logic                         start3,
    input  logic [WIDTH-1:0]             R,
    output logic                         ack3,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         done,
    output logic [2:0]                   err
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    localparam logic [DW-1:0] DLY_LOAD = DW'(ACK_DELAY - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Fibonacci feedback taps (bit i set = stage i feeds the XOR).
    // WIDTH=8 uses x^8+x^6+x^5+x^4+1; a few other common widths are provided.
    function automatic logic [WIDTH-1:0] lfsr_taps();
        logic [WIDTH-1:0] m;
        m = '0;
        case (WIDTH)
            4:       m = WIDTH'(4'b1100);
            8:       m = WIDTH'(8'b1011_1000);
            16:      m = WIDTH'(16'hB400);
            32:      m = WIDTH'(32'h8020_0003);
            default: m = WIDTH'(3) << (WIDTH - 2);
        endcase
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAPS = lfsr_taps();

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT2 = 3'd1,
        ACK2  = 3'd2,
        WAIT3 = 3'd3,
        ACK3  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DW-1:0]    r_cnt;
    logic [DW-1:0]    w_cnt_nxt;

    // Strobes from the FSM to the datapath; all act on the clock edge that
    // ends the current cycle.
    logic             w_serve;      // edge that raises ack2
    logic             w_return;     // edge that raises ack3
    logic             w_latch_r;    // return request accepted in IDLE
    logic             w_proto_err;  // start seen where it cannot be accepted

    // Datapath registers
    logic             r_ack2;
    logic             r_ack3;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_lfsr;
    logic [CW-1:0]    r_count;
    logic             r_done;
    logic [2:0]       r_err;

    logic [WIDTH-1:0] w_lfsr_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_mismatch;

    // State and delay-counter register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic and datapath strobes.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch; blocking '=' is correct here.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_serve     = 1'b0;
        w_return    = 1'b0;
        w_latch_r   = 1'b0;
        w_proto_err = 1'b0;

        case (r_state)
            IDLE: begin
                if (start2) begin
                    // Fetch wins a same-cycle collision; the return is dropped.
                    w_state_nxt = WAIT2;
                    w_cnt_nxt   = DLY_LOAD;
                    w_proto_err = start3;
                end else if (start3) begin
                    w_state_nxt = WAIT3;
                    w_cnt_nxt   = DLY_LOAD;
                    w_latch_r   = 1'b1;
                end
            end

            WAIT2: begin
                w_proto_err = start2 | start3;
                if (r_cnt == '0) begin
                    w_state_nxt = ACK2;
                    w_serve     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - DW'(1);
                end
            end

            WAIT3: begin
                w_proto_err = start2 | start3;
                if (r_cnt == '0) begin
                    w_state_nxt = ACK3;
                    w_return    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - DW'(1);
                end
            end

            ACK2, ACK3: begin
                // The ack cycle itself; a new start is only accepted in IDLE.
                w_proto_err = start2 | start3;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_lfsr_nxt = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);

`ifdef ORD_RESP_CHECK_EN
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_ret;
    logic [WIDTH-1:0] w_top;

    // History write port: the served byte is pushed at the occupancy index.
    // NOTE: the history array and the latched return byte carry no reset;
    // occupancy alone decides which entries are valid.
    always_ff @(posedge Clk) begin
        if (w_serve && !w_full) begin
            r_mem[AW'(r_count)] <= r_lfsr;
        end
    end

    // Capture the returned byte when a return request is accepted.
    always_ff @(posedge Clk) begin
        if (w_latch_r) begin
            r_ret <= R;
        end
    end

    assign w_top      = r_mem[AW'(r_count - CW'(1))];
    assign w_mismatch = (w_top != r_ret);
`else
    logic w_unused_r;

    assign w_unused_r = ^R;
    assign w_mismatch = 1'b0;
`endif

    // Handshake outputs, served byte, occupancy, done and sticky error flags.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ack2  <= 1'b0;
            r_ack3  <= 1'b0;
            r_b     <= '0;
            r_lfsr  <= SEED;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_ack2 <= w_serve;
            r_ack3 <= w_return;

            if (w_serve) begin
                r_b    <= r_lfsr;
                r_lfsr <= w_lfsr_nxt;
                r_done <= 1'b0;
                if (w_full) begin
                    r_err[1] <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end

            if (w_return) begin
                if (w_empty) begin
                    r_err[1] <= 1'b1;
                end else begin
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_done <= 1'b1;
                    end
                    if (w_mismatch) begin
                        r_err[0] <= 1'b1;
                    end
                end
            end

            if (w_proto_err) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    assign ack2  = r_ack2;
    assign ack3  = r_ack3;
    assign B     = r_b;
    assign count = r_count;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_ord_responder.sv
// tb_ord_responder: scoreboard bench for ord_responder.
// Each fetch/return pushes its expected ack-time outputs onto a queue; a
// monitor pops and compares on every ack pulse. An ack with nothing queued
// is reported, which also catches stretched or spurious acks.

module tb_ord_responder;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 16;
    localparam int         ACK_DELAY = 2;
    localparam logic [7:0] SEED      = 8'h01;
    localparam int         TIMEOUT   = 20;

`ifdef ORD_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst;
    logic       start2;
    logic       ack2;
    logic [7:0] B;
    logic       start3;
    logic [7:0] R;
    logic       ack3;
    logic [4:0] count;
    logic       done;
    logic [2:0] err;

    always #5 Clk = ~Clk;

    ord_responder #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .SEED      (SEED),
        .ACK_DELAY (ACK_DELAY)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .start2 (start2),
        .ack2   (ack2),
        .B      (B),
        .start3 (start3),
        .R      (R),
        .ack3   (ack3),
        .count  (count),
        .done   (done),
        .err    (err)
    );

    typedef struct {
        logic [7:0] b;
        logic [4:0] cnt;
        logic       done;
        logic [2:0] err;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0] m_lfsr;
    logic [7:0] m_b;
    logic [7:0] m_hist[$];
    logic       m_done;
    logic [2:0] m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // x^8+x^6+x^5+x^4+1, shifting toward the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        m_b    = 8'h00;
        m_hist.delete();
        m_done = 1'b0;
        m_err  = 3'b000;
    endtask

    task automatic model_fetch(output exp_t e);
        m_b    = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        m_done = 1'b0;
        if (m_hist.size() < DEPTH) m_hist.push_back(m_b);
        else                       m_err[1] = 1'b1;
        e.b    = m_b;
        e.cnt  = 5'(m_hist.size());
        e.done = m_done;
        e.err  = m_err;
    endtask

    task automatic model_return(input logic [7:0] r, output exp_t e);
        logic [7:0] v;
        if (m_hist.size() > 0) begin
            v = m_hist.pop_back();
            if (CHK && v != r) m_err[0] = 1'b1;
            if (m_hist.size() == 0) m_done = 1'b1;
        end else begin
            m_err[1] = 1'b1;
        end
        e.b    = m_b;
        e.cnt  = 5'(m_hist.size());
        e.done = m_done;
        e.err  = m_err;
    endtask

    // Scoreboard compare on every ack pulse, sampled away from the active edge.
    always @(negedge Clk) begin
        exp_t e;
        if (ack2 === 1'b1) begin
            check("ack2_expected", 32'(q2.size() > 0), 32'(1));
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("ack2_B",     32'(B),     32'(e.b));
                check("ack2_count", 32'(count), 32'(e.cnt));
                check("ack2_done",  32'(done),  32'(e.done));
                check("ack2_err",   32'(err),   32'(e.err));
            end
        end
        if (ack3 === 1'b1) begin
            check("ack3_expected", 32'(q3.size() > 0), 32'(1));
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("ack3_B",     32'(B),     32'(e.b));
                check("ack3_count", 32'(count), 32'(e.cnt));
                check("ack3_done",  32'(done),  32'(e.done));
                check("ack3_err",   32'(err),   32'(e.err));
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        Rst = 1'b1;
        idle(cycles);
        Rst = 1'b0;
        model_reset();
    endtask

    // One fetch; optionally collides with a return request in the same cycle.
    task automatic do_fetch(input bit also3, output logic [7:0] served);
        exp_t e;
        int   n;
        if (also3) m_err[2] = 1'b1;
        model_fetch(e);
        q2.push_back(e);
        served = e.b;
        start2 = 1'b1;
        start3 = also3;
        R      = 8'hA5;
        @(posedge Clk); #1;
        start2 = 1'b0;
        start3 = 1'b0;
        n = 0;
        while (ack2 !== 1'b1 && n < TIMEOUT) begin
            @(posedge Clk); #1;
            n++;
        end
        check("ack2_latency", 32'(n), 32'(ACK_DELAY));
        @(posedge Clk); #1;
        check("ack2_one_cycle", 32'(ack2), 32'(0));
    endtask

    // One return; optionally pokes start2 while the responder is in WAIT3.
    task automatic do_return(input logic [7:0] r, input bit poke2);
        exp_t e;
        int   n;
        if (poke2) m_err[2] = 1'b1;
        model_return(r, e);
        q3.push_back(e);
        start3 = 1'b1;
        R      = r;
        @(posedge Clk); #1;
        start3 = 1'b0;
        R      = ~r;
        start2 = poke2;
        n = 0;
        while (ack3 !== 1'b1 && n < TIMEOUT) begin
            @(posedge Clk); #1;
            start2 = 1'b0;
            n++;
        end
        start2 = 1'b0;
        check("ack3_latency", 32'(n), 32'(ACK_DELAY));
        @(posedge Clk); #1;
        check("ack3_one_cycle", 32'(ack3), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s [0:19];

        Rst    = 1'b1;
        start2 = 1'b0;
        start3 = 1'b0;
        R      = 8'h00;
        model_reset();

        // Reset held for three cycles: every output idle.
        idle(3);
        Rst = 1'b0;
        check("rst_ack2",  32'(ack2),  32'(0));
        check("rst_ack3",  32'(ack3),  32'(0));
        check("rst_B",     32'(B),     32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_done",  32'(done),  32'(0));
        check("rst_err",   32'(err),   32'(0));

        // Single fetch serves the seed.
        idle(2);
        do_fetch(1'b0, s[0]);

        // Five fetches, returned in reverse order of service.
        for (int i = 1; i < 5; i++) do_fetch(1'b0, s[i]);
        for (int i = 4; i >= 0; i--) do_return(s[i], 1'b0);
        check("lifo_done",  32'(done),  32'(1));
        check("lifo_count", 32'(count), 32'(0));
        check("lifo_err",   32'(err),   32'(0));

        // Two fetches returned in forward order.
        do_fetch(1'b0, s[0]);
        check("done_cleared", 32'(done), 32'(0));
        do_fetch(1'b0, s[1]);
        do_return(s[0], 1'b0);
        do_return(s[1], 1'b0);
        check("fwd_err0",  32'(err[0]), 32'(CHK));
        check("fwd_count", 32'(count),  32'(0));

        // Overflow: 17 fetches into a 16-deep history, drain, then underflow.
        do_reset(2);
        for (int i = 0; i < 17; i++) do_fetch(1'b0, s[i]);
        check("ovf_count", 32'(count),  32'(16));
        check("ovf_err1",  32'(err[1]), 32'(1));
        for (int i = 15; i >= 0; i--) do_return(s[i], 1'b0);
        check("drain_count", 32'(count), 32'(0));
        do_return(8'h3C, 1'b0);
        check("udf_err1",  32'(err[1]), 32'(1));
        check("udf_count", 32'(count),  32'(0));

        // Same-cycle collision: fetch wins, no ack3 may follow.
        do_reset(2);
        do_fetch(1'b1, s[0]);
        idle(ACK_DELAY + 3);
        check("collide_err2", 32'(err[2]), 32'(1));

        // Reset while in WAIT2 aborts the fetch and reseeds the LFSR.
        do_reset(2);
        start2 = 1'b1;
        @(posedge Clk); #1;
        start2 = 1'b0;
        Rst    = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        idle(ACK_DELAY + 3);
        check("abort_count", 32'(count), 32'(0));
        check("abort_B",     32'(B),     32'(0));
        do_fetch(1'b0, s[0]);
        check("reseed_B", 32'(B), 32'(SEED));

        // start2 during WAIT3 is ignored and flagged.
        do_return(s[0], 1'b1);
        idle(ACK_DELAY + 3);
        check("wait_poke_err2", 32'(err[2]), 32'(1));
        check("wait_poke_done", 32'(done),   32'(1));

        idle(4);
        check("q2_drained", 32'(q2.size()), 32'(0));
        check("q3_drained", 32'(q3.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
